// File: rtl/mp_add_sequencer_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
package mp_add_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/mp_add_sequencer_if.sv
// Word-stream bus between host/DMA, the sequencer and the downstream sum consumer.
interface mp_add_sequencer_if;
   import mp_add_pkg::*;

   // Both streams use the same valid/ready rule: a beat transfers on the rising edge
   // where valid and ready are both high; once valid rises, the payload stays stable
   // until that transfer happens.
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] a_word;
   logic [DATA_W-1:0] b_word;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] sum_word;
   logic              out_last;

   modport master (
      output in_valid, a_word, b_word, out_ready,
      input  in_ready, out_valid, sum_word, out_last
   );

   modport slave (
      input  in_valid, a_word, b_word, out_ready,
      output in_ready, out_valid, sum_word, out_last
   );

endinterface

// File: rtl/mp_add_sequencer_csa32.sv
// 32-bit carry-skip adder: 4-bit ripple blocks, block carry bypassed when all bits propagate.
module csa32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);

   localparam int BLK_W = 4;
   localparam int N_BLK = 32 / BLK_W;

   logic c_blk;
   logic c_ripple;
   logic blk_prop;
   logic p;

   always_comb begin
      sum      = '0;
      c_blk    = cin;
      c_ripple = cin;
      blk_prop = 1'b1;
      p        = 1'b0;
      for (int k = 0; k < N_BLK; k++) begin
         c_ripple = c_blk;
         blk_prop = 1'b1;
         for (int i = 0; i < BLK_W; i++) begin
            p                  = a[k*BLK_W+i] ^ b[k*BLK_W+i];
            sum[k*BLK_W+i]     = p ^ c_ripple;
            c_ripple           = (a[k*BLK_W+i] & b[k*BLK_W+i]) | (p & c_ripple);
            blk_prop           = blk_prop & p;
         end
         // A fully propagating block passes its incoming carry straight through.
         c_blk = blk_prop ? c_blk : c_ripple;
      end
      cout = c_blk;
   end

endmodule

// File: rtl/mp_add_sequencer.sv
// Streams WORDS-word add/subtract through one 32-bit adder, chaining carry between cycles.
module mp_add_sequencer
   import mp_add_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     op_sub,
   input  logic                     abort,
   mp_add_sequencer_if.slave        bus,
   output logic                     busy,
   output logic                     done,
   output logic                     carry_out,
   output state_t                   dbg_state
);

   localparam int               CNT_W    = $clog2(WORDS + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

   state_t            state_q;
   state_t            state_d;
   logic              op_sub_q;
   logic              carry_q;
   logic [CNT_W-1:0]  word_cnt;
   logic [DATA_W-1:0] sum_q;
   logic              out_valid_q;
   logic              out_last_q;
   logic              done_q;
   logic              carry_out_q;

   logic              in_ready_c;
   logic              in_fire;
   logic              out_fire;
   logic              last_in;
   logic [DATA_W-1:0] add_b;
   logic [DATA_W-1:0] add_s;
   logic              add_co;

   // One-entry output register: a new pair is taken only if the slot is free or draining now.
   assign in_ready_c = (state_q == RUN) && (!out_valid_q || bus.out_ready) && !abort;
   assign in_fire    = bus.in_valid && in_ready_c;
   assign out_fire   = out_valid_q && bus.out_ready;
   assign last_in    = (word_cnt == LAST_IDX);

   // Subtraction is A + ~B with the carry chain seeded to 1 at start.
   assign add_b = op_sub_q ? ~bus.b_word : bus.b_word;

   csa32 u_adder (
      .a    (bus.a_word),
      .b    (add_b),
      .cin  (carry_q),
      .sum  (add_s),
      .cout (add_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start)                  state_d = RUN;
            RUN:     if (in_fire && last_in)     state_d = DRAIN;
            DRAIN:   if (out_fire && out_last_q) state_d = IDLE;
            default:                             state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_sub_q    <= 1'b0;
         carry_q     <= 1'b0;
         word_cnt    <= '0;
         sum_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
         carry_out_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            carry_q     <= 1'b0;
            word_cnt    <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     op_sub_q <= op_sub;
                     carry_q  <= op_sub;
                     word_cnt <= '0;
                  end
               end
               RUN: begin
                  if (in_fire) begin
                     sum_q       <= add_s;
                     out_valid_q <= 1'b1;
                     out_last_q  <= last_in;
                     carry_q     <= add_co;
                     word_cnt    <= word_cnt + CNT_W'(1);
                  end else if (out_fire) begin
                     out_valid_q <= 1'b0;
                  end
               end
               DRAIN: begin
                  if (out_fire && out_last_q) begin
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     done_q      <= 1'b1;
                     carry_out_q <= carry_q;
                  end
               end
               default: begin
                  out_valid_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.sum_word  = sum_q;
   assign bus.out_last  = out_last_q;
   assign busy          = (state_q != IDLE);
   assign done          = done_q;
   assign carry_out     = carry_out_q;
   assign dbg_state     = state_q;

endmodule
